// File: rtl/seq_stim_ctrl_if.sv
// Bundle between the stimulus sequencer, the board controls and the pattern FSM.
// The master modport is the sequencer side; the slave modport is the board/FSM side.
interface seq_stim_ctrl_if #(
  parameter int PAT_LEN = 16,
  parameter int CNT_W   = $clog2(PAT_LEN + 1)
);
  localparam int IDX_W = $clog2(PAT_LEN);

  logic               start;
  logic               abort;
  logic [PAT_LEN-1:0] pattern;
  logic [4:0]         div_sel;
  logic               fsm_out;
  logic               w;
  logic               step_en;
  logic               fsm_rst;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   det_count;
  logic [IDX_W-1:0]   step_idx;

  modport master (
    input  start, abort, pattern, div_sel, fsm_out,
    output w, step_en, fsm_rst, busy, done, det_count, step_idx
  );

  modport slave (
    output start, abort, pattern, div_sel, fsm_out,
    input  w, step_en, fsm_rst, busy, done, det_count, step_idx
  );
endinterface

// File: rtl/seq_stim_ctrl.sv
// Steps a latched bit pattern into a single-input FSM, one bit per programmable tick,
// and counts detections. Define SEQ_STIM_LOOP_EN to replay the pattern until abort.
module seq_stim_ctrl #(
  parameter int PAT_LEN = 16,
  parameter int DIV_W   = 26,
  parameter int CNT_W   = $clog2(PAT_LEN + 1)
) (
  input  logic           clk,
  input  logic           reset,
  seq_stim_ctrl_if.master bus
);
  localparam int IDX_W = $clog2(PAT_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_RUN    = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic [4:0]         div_q, div_d, div_clamp_s;
  logic [DIV_W-1:0]   presc_q, presc_d, tick_mask_s;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   det_q, det_d;
  logic               w_q, w_d;
  logic               step_en_q, step_en_d;
  logic               fsm_rst_q, fsm_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_prev_q, start_prev_d;
  logic               pend_q, pend_d;
  logic               start_rise_s, tick_s, last_idx_s;
`ifdef SEQ_STIM_LOOP_EN
  logic               last_q, last_d;
`endif

  function automatic logic [CNT_W-1:0] det_add(input logic [CNT_W-1:0] cnt, input logic hit);
`ifdef SEQ_STIM_LOOP_EN
    if (hit && (cnt != {CNT_W{1'b1}})) begin
      det_add = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      det_add = cnt;
    end
`else
    det_add = cnt + {{(CNT_W-1){1'b0}}, hit};
`endif
  endfunction

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    start_rise_s = bus.start & ~start_prev_q;
    div_clamp_s  = (int'(bus.div_sel) > DIV_W) ? 5'(DIV_W) : bus.div_sel;
    tick_mask_s  = ~({DIV_W{1'b1}} << div_q);
    tick_s       = (presc_q == tick_mask_s);
    last_idx_s   = (idx_q == IDX_W'(PAT_LEN - 1));

    state_d      = state_q;
    pattern_d    = pattern_q;
    div_d        = div_q;
    presc_d      = presc_q;
    idx_d        = idx_q;
    w_d          = w_q;
    step_en_d    = 1'b0;
    fsm_rst_d    = 1'b0;
    pend_d       = 1'b0;
    start_prev_d = bus.start;
`ifdef SEQ_STIM_LOOP_EN
    last_d       = 1'b0;
`endif

    // The FSM advances on the edge closing the step_en cycle, so its output is
    // only meaningful one cycle later; the sample is applied then.
    if (pend_q) begin
      det_d = det_add(det_q, bus.fsm_out);
    end else begin
      det_d = det_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise_s) begin
          state_d   = S_CLR;
          pattern_d = bus.pattern;
          div_d     = div_clamp_s;
          det_d     = {CNT_W{1'b0}};
          idx_d     = {IDX_W{1'b0}};
          presc_d   = {DIV_W{1'b0}};
          fsm_rst_d = 1'b1;
        end else begin
          state_d   = state_q;
        end
      end
      S_CLR: begin
        state_d = S_RUN;
        presc_d = {DIV_W{1'b0}};
      end
      S_RUN: begin
        if (tick_s) begin
          w_d       = pattern_q[idx_q];
          step_en_d = 1'b1;
          presc_d   = {DIV_W{1'b0}};
          state_d   = S_SAMPLE;
        end else begin
          presc_d   = presc_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      S_SAMPLE: begin
        pend_d  = 1'b1;
        presc_d = {DIV_W{1'b0}};
        if (last_idx_s) begin
`ifdef SEQ_STIM_LOOP_EN
          last_d  = 1'b1;
          idx_d   = {IDX_W{1'b0}};
          state_d = S_RUN;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef SEQ_STIM_LOOP_EN
    busy_d = (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_SAMPLE);
    done_d = pend_q & last_q;
`else
    // busy covers the trailing sample so done only rises once det_count is final.
    busy_d = (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_SAMPLE) || pend_d;
    done_d = (state_d == S_DONE) && !pend_d;
`endif

    if (bus.abort) begin
      state_d   = S_IDLE;
      w_d       = 1'b0;
      step_en_d = 1'b0;
      fsm_rst_d = 1'b0;
      pend_d    = 1'b0;
      presc_d   = {DIV_W{1'b0}};
      det_d     = det_q;
      idx_d     = idx_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
`ifdef SEQ_STIM_LOOP_EN
      last_d    = 1'b0;
`endif
    end else begin
      state_d   = state_d;
    end
  end

  // State and registered-output flops; start history resets high so a held start cannot fire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pattern_q    <= {PAT_LEN{1'b0}};
      div_q        <= 5'd0;
      presc_q      <= {DIV_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      det_q        <= {CNT_W{1'b0}};
      w_q          <= 1'b0;
      step_en_q    <= 1'b0;
      fsm_rst_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b1;
      pend_q       <= 1'b0;
`ifdef SEQ_STIM_LOOP_EN
      last_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      div_q        <= div_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      det_q        <= det_d;
      w_q          <= w_d;
      step_en_q    <= step_en_d;
      fsm_rst_q    <= fsm_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_prev_q <= start_prev_d;
      pend_q       <= pend_d;
`ifdef SEQ_STIM_LOOP_EN
      last_q       <= last_d;
`endif
    end
  end

  assign bus.w         = w_q;
  assign bus.step_en   = step_en_q;
  assign bus.fsm_rst   = fsm_rst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.det_count = det_q;
  assign bus.step_idx  = idx_q;

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Scoreboard bench for seq_stim_ctrl (PAT_LEN=8, DIV_W=4); covers SEQ_STIM_LOOP_EN when defined.
module tb_seq_stim_ctrl;
  localparam int PAT_LEN = 8;
  localparam int DIV_W   = 4;
  localparam int CNT_W   = 4;

  typedef struct {
    logic w;
    int   idx;
    int   gap;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  logic tie1;
  logic fsm_reg;
  int   cyc = 0;
  int   ref_cyc = 0;
  int   rst_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic done_prev = 1'b0;
  step_t step_q[$];
  int    done_q[$];

  seq_stim_ctrl_if #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) bus ();

  seq_stim_ctrl #(.PAT_LEN(PAT_LEN), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural FSM: output is the last stepped-in w, cleared by fsm_rst.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           fsm_reg <= 1'b0;
    else if (bus.fsm_rst) fsm_reg <= 1'b0;
    else if (bus.step_en) fsm_reg <= bus.w;
  end
  assign bus.fsm_out = tie1 ? 1'b1 : fsm_reg;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a step or a run completion appears.
  initial begin
    step_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.fsm_rst) begin
          rst_cnt++;
          ref_cyc = cyc;
        end
        if (bus.step_en) begin
          if (step_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL step_unexpected: step_en at idx %0d, none expected", bus.step_idx);
          end else begin
            e = step_q.pop_front();
            check("step_w", bus.w, e.w);
            check("step_idx", bus.step_idx, e.idx);
            check("step_gap", cyc - ref_cyc, e.gap);
          end
          ref_cyc = cyc;
        end
        if (bus.done && !done_prev) begin
          if (done_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_unexpected: done rose with det_count %0d", bus.det_count);
          end else begin
            check("done_det_count", bus.det_count, done_q.pop_front());
          end
        end
        done_prev = bus.done;
      end else begin
        done_prev = 1'b0;
      end
    end
  end

  task automatic push_steps(input logic [7:0] pat, input int gap, input int n);
    step_t e;
    for (int i = 0; i < n; i++) begin
      e.w   = pat[i % PAT_LEN];
      e.idx = i % PAT_LEN;
      e.gap = gap;
      step_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (!bus.done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.done, 1);
  endtask

  task automatic wait_idx(input int idx, input int det, input int budget, input string name);
    int k = 0;
    while (!(bus.step_idx == idx && (det < 0 || bus.det_count == det)) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, (bus.step_idx == idx), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w"}, bus.w, 0);
    check({tag, "_step_en"}, bus.step_en, 0);
    check({tag, "_fsm_rst"}, bus.fsm_rst, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_det_count"}, bus.det_count, 0);
    check({tag, "_step_idx"}, bus.step_idx, 0);
  endtask

  task automatic run_oneshot(input logic [7:0] pat, input logic [4:0] dsel, input int gap,
                             input int det, input string name);
    bus.pattern = pat;
    bus.div_sel = dsel;
    tie1        = 1'b0;
    rst_cnt     = 0;
    push_steps(pat, gap, PAT_LEN);
    done_q.push_back(det);
    pulse_start();
    wait_done(PAT_LEN * (gap + 1) + 10, {name, "_done"});
    @(negedge clk);
    check({name, "_idx_held"}, bus.step_idx, PAT_LEN - 1);
    check({name, "_busy_low"}, bus.busy, 0);
    check({name, "_one_fsm_rst"}, rst_cnt, 1);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = 8'h00;
    bus.div_sel = 5'd0;
    tie1        = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    @(negedge clk);

`ifndef SEQ_STIM_LOOP_EN
    // w sequence 0,1,1,1,0,1,1,0 -> five detections, steps two cycles apart
    run_oneshot(8'b0110_1110, 5'd0, 2, 5, "oneshot");
    run_oneshot(8'h0B, 5'd3, 9, 3, "div3");
    run_oneshot(8'hA5, 5'd31, 17, 4, "div_clamp");

    // Restart from DONE with new pattern; mid-run pin changes and start edges are ignored.
    bus.pattern = 8'hFF;
    bus.div_sel = 5'd0;
    tie1        = 1'b1;
    rst_cnt     = 0;
    push_steps(8'hFF, 2, PAT_LEN);
    done_q.push_back(8);
    bus.start = 1'b1;
    @(negedge clk);
    check("restart_fsm_rst", bus.fsm_rst, 1);
    check("restart_det_clr", bus.det_count, 0);
    check("restart_busy", bus.busy, 1);
    bus.start   = 1'b0;
    bus.pattern = 8'h00;
    bus.div_sel = 5'd3;
    wait_idx(2, -1, 40, "restart_reach_idx2");
    pulse_start();
    wait_done(60, "restart_done");
    check("restart_one_fsm_rst", rst_cnt, 1);
    @(negedge clk);
`else
    // Continuous replay: three pass ends, then abort.
    bus.pattern = 8'h00;
    bus.div_sel = 5'd0;
    tie1        = 1'b1;
    push_steps(8'h00, 2, 3 * PAT_LEN + 1);
    done_q.push_back(8);
    done_q.push_back(15);
    done_q.push_back(15);
    pulse_start();
    begin
      int seen = 0;
      int k    = 0;
      logic prev = 1'b0;
      while (seen < 3 && k < 200) begin
        @(negedge clk);
        if (bus.done && !prev) seen++;
        prev = bus.done;
        k++;
      end
      check("loop_three_passes", seen, 3);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("loop_abort_busy", bus.busy, 0);
    check("loop_abort_done", bus.done, 0);
    check("loop_abort_det_held", bus.det_count, 15);
    @(negedge clk);
`endif

    // Abort at step_idx 3 with two detections; simultaneous start is ignored.
    bus.pattern = 8'b0110_1110;
    bus.div_sel = 5'd2;
    tie1        = 1'b0;
    push_steps(8'b0110_1110, 5, 3);
    pulse_start();
    wait_idx(3, 2, 60, "abort_reach_idx3");
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_w", bus.w, 0);
    check("abort_step_en", bus.step_en, 0);
    check("abort_det_held", bus.det_count, 2);
    check("abort_idx_held", bus.step_idx, 3);
    bus.abort = 1'b0;
    rst_cnt   = 0;
    repeat (5) @(negedge clk);
    check("abort_start_ignored", bus.busy, 0);
    check("abort_no_fsm_rst", rst_cnt, 0);
    bus.start = 1'b0;
    @(negedge clk);

    // Reset mid-run at step_idx 5, then release with start held high.
    bus.pattern = 8'hFF;
    bus.div_sel = 5'd2;
    tie1        = 1'b1;
    push_steps(8'hFF, 5, 5);
    pulse_start();
    wait_idx(5, -1, 60, "reset_reach_idx5");
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    rst_cnt = 0;
    repeat (6) @(negedge clk);
    check("held_start_no_run", bus.busy, 0);
    check("held_start_no_fsm_rst", rst_cnt, 0);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    check("fresh_start_fsm_rst", bus.fsm_rst, 1);
    check("fresh_start_busy", bus.busy, 1);
    bus.abort = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    check("final_abort_busy", bus.busy, 0);
    @(negedge clk);

    check("steps_left", step_q.size(), 0);
    check("dones_left", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
